// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite signal bundle between an initiator and the SRAM responder.
interface ahb_sram_slave_if #(
    parameter int ADDR_W = 12
);
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [31:0]       HWDATA;
    logic              HREADY;
    logic [31:0]       HRDATA;
    logic              HREADYOUT;
    logic [1:0]        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder fronting a word-organised SRAM with byte lanes,
// programmable wait states, two-cycle ERROR response and read-after-write forwarding.
module ahb_sram_slave #(
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input logic             HCLK,
    input logic             HRESET,
    ahb_sram_slave_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-2:0] DEPTH_L = (ADDR_W-1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             dp_valid_q, dp_valid_d;
    logic             dp_write_q, dp_write_d;
    logic [IDX_W-1:0] dp_idx_q, dp_idx_d;
    logic [3:0]       dp_be_q, dp_be_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      mem [DEPTH];

    logic             ready, accept, aligned, legal, wr_en, fwd_hit;
    logic [ADDR_W-3:0] addr_idx;
    logic [IDX_W-1:0] new_idx;
    logic [3:0]       new_be;
    logic [31:0]      wr_merged;
    logic             unused_htrans0;

    assign unused_htrans0 = bus.HTRANS[0];

    assign ready    = (state_q == S_IDLE) || (state_q == S_ERR2);
    assign accept   = bus.HSEL && bus.HREADY && bus.HTRANS[1] && ready;
    assign addr_idx = bus.HADDR[ADDR_W-1:2];
    assign new_idx  = bus.HADDR[IDX_W+1:2];
    assign aligned  = (bus.HSIZE == 3'b001) ? !bus.HADDR[0] :
                      (bus.HSIZE == 3'b010) ? (bus.HADDR[1:0] == 2'b00) : 1'b1;
    assign legal    = (bus.HSIZE <= 3'b010) && aligned && ({1'b0, addr_idx} < DEPTH_L);
    assign wr_en    = ready && dp_valid_q && dp_write_q;
    assign fwd_hit  = wr_en && (dp_idx_q == new_idx);

    always_comb begin
        new_be = 4'b0000;
        case (bus.HSIZE)
            3'b000:  new_be[bus.HADDR[1:0]] = 1'b1;
            3'b001:  new_be = bus.HADDR[1] ? 4'b1100 : 4'b0011;
            default: new_be = 4'b1111;
        endcase
    end

    // The completing write word doubles as the forwarding source for a same-word read.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wr_merged[8*i +: 8] = dp_be_q[i] ? bus.HWDATA[8*i +: 8] : mem[dp_idx_q][8*i +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_idx_d   = dp_idx_q;
        dp_be_d    = dp_be_q;
        rdata_d    = rdata_q;
        if (ready && dp_valid_q) begin
            dp_valid_d = 1'b0;
        end
        case (state_q)
            S_IDLE, S_ERR2: begin
                state_d = S_IDLE;
                if (accept) begin
                    dp_write_d = bus.HWRITE;
                    dp_idx_d   = new_idx;
                    dp_be_d    = new_be;
                    if (!legal) begin
                        state_d    = S_ERR1;
                        dp_valid_d = 1'b0;
                    end else begin
                        dp_valid_d = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_d = S_WAIT;
                            cnt_d   = 4'(WAIT_STATES);
                        end else if (!bus.HWRITE) begin
                            rdata_d = fwd_hit ? wr_merged : mem[new_idx];
                        end
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_IDLE;
                    if (!dp_write_q) begin
                        rdata_d = mem[dp_idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_idx_q   <= '0;
            dp_be_q    <= 4'b0000;
            rdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_idx_q   <= dp_idx_d;
            dp_be_q    <= dp_be_d;
            rdata_q    <= rdata_d;
        end
    end

    // Array contents deliberately survive reset; wr_en is already gated by the reset flops.
    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            mem[dp_idx_q] <= wr_merged;
        end
    end

    assign bus.HREADYOUT = ready;
    assign bus.HRESP     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;
    assign bus.HRDATA    = rdata_q;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: zero-wait instance (dut0) and two-wait-state, half-depth instance (dut2).
module tb_ahb_sram_slave;
    logic HCLK = 1'b0;
    logic HRESET;
    int   checks = 0;
    int   failures = 0;
    int   lows;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_NS   = 2'b10;
    localparam logic [2:0] SZ_B   = 3'b000;
    localparam logic [2:0] SZ_H   = 3'b001;
    localparam logic [2:0] SZ_W   = 3'b010;

    ahb_sram_slave_if #(.ADDR_W(12)) bus0 ();
    ahb_sram_slave_if #(.ADDR_W(12)) bus2 ();

    assign bus0.HREADY = bus0.HREADYOUT;
    assign bus2.HREADY = bus2.HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahb_sram_slave #(.ADDR_W(12), .DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .bus(bus0)
    );

    ahb_sram_slave #(.ADDR_W(12), .DEPTH(512), .WAIT_STATES(2)) dut2 (
        .HCLK(HCLK), .HRESET(HRESET), .bus(bus2)
    );

    // Single comparison point; every check in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int d, input logic sel, input logic [1:0] trans,
                                 input logic write, input logic [2:0] size,
                                 input logic [11:0] addr, input logic [31:0] wdata);
        if (d == 0) begin
            bus0.HSEL = sel; bus0.HTRANS = trans; bus0.HWRITE = write;
            bus0.HSIZE = size; bus0.HADDR = addr; bus0.HWDATA = wdata;
        end else begin
            bus2.HSEL = sel; bus2.HTRANS = trans; bus2.HWRITE = write;
            bus2.HSIZE = size; bus2.HADDR = addr; bus2.HWDATA = wdata;
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? bus0.HREADYOUT : bus2.HREADYOUT;
    endfunction

    function automatic logic [1:0] rsp(input int d);
        return (d == 0) ? bus0.HRESP : bus2.HRESP;
    endfunction

    function automatic logic [31:0] rdat(input int d);
        return (d == 0) ? bus0.HRDATA : bus2.HRDATA;
    endfunction

    // Counts HREADYOUT-low cycles from now, bounded so a stuck slave cannot hang the run.
    task automatic waitReady(input int d, output int n);
        n = 0;
        while (!rdy(d) && n < 20) begin
            n++;
            step();
        end
    endtask

    task automatic errSeq(input int d, input logic write, input logic [2:0] size,
                          input logic [11:0] addr, input string tag, input logic [31:0] held);
        applyStimulus(d, 1'b1, T_NS, write, size, addr, 32'h0);
        step();
        applyStimulus(d, 1'b0, T_IDLE, 1'b0, SZ_W, 12'h0, 32'hFFFF_FFFF);
        checkOutput({tag, "_e1_ready"}, 32'(rdy(d)), 32'd0);
        checkOutput({tag, "_e1_resp"}, 32'(rsp(d)), 32'd1);
        step();
        checkOutput({tag, "_e2_ready"}, 32'(rdy(d)), 32'd1);
        checkOutput({tag, "_e2_resp"}, 32'(rsp(d)), 32'd1);
        checkOutput({tag, "_e2_rdata"}, rdat(d), held);
        step();
        checkOutput({tag, "_ok_ready"}, 32'(rdy(d)), 32'd1);
        checkOutput({tag, "_ok_resp"}, 32'(rsp(d)), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        HRESET = 1'b1;
        applyStimulus(0, 1'b0, T_IDLE, 1'b0, SZ_W, 12'h0, 32'h0);
        applyStimulus(2, 1'b0, T_IDLE, 1'b0, SZ_W, 12'h0, 32'h0);
        step();
        step();
        checkOutput("reset_ready", 32'(bus0.HREADYOUT), 32'd1);
        checkOutput("reset_resp", 32'(bus0.HRESP), 32'd0);
        checkOutput("reset_rdata", bus0.HRDATA, 32'h0);
        HRESET = 1'b0;
        step();

        // Zero-wait write then same-word read in the next address phase (forwarded).
        applyStimulus(0, 1'b1, T_NS, 1'b1, SZ_W, 12'h010, 32'h0);
        step();
        applyStimulus(0, 1'b1, T_NS, 1'b0, SZ_W, 12'h010, 32'hDEAD_BEEF);
        step();
        checkOutput("ws0_fwd_rdata", bus0.HRDATA, 32'hDEAD_BEEF);
        checkOutput("ws0_fwd_ready", 32'(bus0.HREADYOUT), 32'd1);
        checkOutput("ws0_fwd_resp", 32'(bus0.HRESP), 32'd0);
        applyStimulus(0, 1'b1, T_NS, 1'b0, SZ_W, 12'h010, 32'h0);
        step();
        checkOutput("ws0_mem_read", bus0.HRDATA, 32'hDEAD_BEEF);

        // Byte and halfword lanes; upper HWDATA bits carry junk that must be masked.
        applyStimulus(0, 1'b1, T_NS, 1'b1, SZ_W, 12'h010, 32'h0);
        step();
        applyStimulus(0, 1'b1, T_NS, 1'b1, SZ_B, 12'h013, 32'h1122_3344);
        step();
        applyStimulus(0, 1'b1, T_NS, 1'b0, SZ_W, 12'h010, 32'hAA99_8877);
        step();
        checkOutput("byte_lane3", bus0.HRDATA, 32'hAA22_3344);
        applyStimulus(0, 1'b1, T_NS, 1'b1, SZ_H, 12'h010, 32'h0);
        step();
        applyStimulus(0, 1'b1, T_NS, 1'b0, SZ_W, 12'h010, 32'hFFFF_5566);
        step();
        checkOutput("half_lanes01", bus0.HRDATA, 32'hAA22_5566);

        // Back-to-back: an unrelated write, then write and forwarded read of 0x020.
        applyStimulus(0, 1'b1, T_NS, 1'b1, SZ_W, 12'h024, 32'h0);
        step();
        applyStimulus(0, 1'b1, T_NS, 1'b1, SZ_W, 12'h020, 32'h0BAD_F00D);
        step();
        applyStimulus(0, 1'b1, T_NS, 1'b0, SZ_W, 12'h020, 32'h1234_5678);
        step();
        checkOutput("b2b_fwd", bus0.HRDATA, 32'h1234_5678);
        applyStimulus(0, 1'b1, T_NS, 1'b0, SZ_W, 12'h024, 32'h0);
        step();
        checkOutput("b2b_other_word", bus0.HRDATA, 32'h0BAD_F00D);
        applyStimulus(0, 1'b0, T_IDLE, 1'b0, SZ_W, 12'h0, 32'h0);
        step();

        // Illegal accesses: misaligned write, misaligned read, reserved size.
        errSeq(0, 1'b1, SZ_W, 12'h012, "mis_wr", 32'h0BAD_F00D);
        errSeq(0, 1'b0, SZ_W, 12'h002, "mis_rd", 32'h0BAD_F00D);
        errSeq(0, 1'b1, 3'b011, 12'h010, "bad_size", 32'h0BAD_F00D);
        applyStimulus(0, 1'b1, T_NS, 1'b0, SZ_W, 12'h010, 32'h0);
        step();
        checkOutput("err_mem_unchanged", bus0.HRDATA, 32'hAA22_5566);
        applyStimulus(0, 1'b0, T_IDLE, 1'b0, SZ_W, 12'h0, 32'h0);

        // Two wait states on both write and read.
        applyStimulus(2, 1'b1, T_NS, 1'b1, SZ_W, 12'h040, 32'h0);
        step();
        applyStimulus(2, 1'b0, T_IDLE, 1'b0, SZ_W, 12'h0, 32'hCAFE_F00D);
        waitReady(2, lows);
        checkOutput("ws2_wr_lows", 32'(lows), 32'd2);
        applyStimulus(2, 1'b1, T_NS, 1'b0, SZ_W, 12'h040, 32'hCAFE_F00D);
        step();
        applyStimulus(2, 1'b0, T_IDLE, 1'b0, SZ_W, 12'h0, 32'h0);
        waitReady(2, lows);
        checkOutput("ws2_rd_lows", 32'(lows), 32'd2);
        checkOutput("ws2_rd_resp", 32'(bus2.HRESP), 32'd0);
        checkOutput("ws2_rd_rdata", bus2.HRDATA, 32'hCAFE_F00D);

        // Word index == DEPTH is out of range.
        errSeq(2, 1'b0, SZ_W, 12'h800, "oor", 32'hCAFE_F00D);

        // Asynchronous reset in the middle of a waited write.
        applyStimulus(2, 1'b1, T_NS, 1'b1, SZ_W, 12'h040, 32'h0);
        step();
        applyStimulus(2, 1'b0, T_IDLE, 1'b0, SZ_W, 12'h0, 32'h5555_5555);
        checkOutput("rst_pre_wait", 32'(bus2.HREADYOUT), 32'd0);
        #2;
        HRESET = 1'b1;
        #1;
        checkOutput("rst_ready", 32'(bus2.HREADYOUT), 32'd1);
        checkOutput("rst_resp", 32'(bus2.HRESP), 32'd0);
        checkOutput("rst_rdata", bus2.HRDATA, 32'h0);
        checkOutput("rst_rdata_dut0", bus0.HRDATA, 32'h0);
        step();
        step();
        HRESET = 1'b0;
        applyStimulus(2, 1'b0, T_IDLE, 1'b0, SZ_W, 12'h0, 32'h0);
        step();
        applyStimulus(2, 1'b1, T_NS, 1'b0, SZ_W, 12'h040, 32'h0);
        step();
        applyStimulus(2, 1'b0, T_IDLE, 1'b0, SZ_W, 12'h0, 32'h0);
        waitReady(2, lows);
        checkOutput("rst_no_write", bus2.HRDATA, 32'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
